// File: rtl/mem_arbiter_if.sv
// Bundle of the two requester ports (fetch and data) plus the shared RAM port
// of the memory arbiter. The slave modport is the arbiter's view; the master
// modport is the view of whatever drives the requests and models the RAM.
interface mem_arbiter_if #(
  parameter int MEM_WIDTH = 10
);
  // Instruction fetch port
  logic                 i_req_i;
  logic [31:0]          i_addr_i;
  logic                 i_gnt_o;
  logic                 i_rvalid_o;
  logic [31:0]          i_rdata_o;
  // Data access port
  logic                 d_req_i;
  logic                 d_we_i;
  logic [31:0]          d_addr_i;
  logic [31:0]          d_wdata_i;
  logic                 d_gnt_o;
  logic                 d_rvalid_o;
  logic [31:0]          d_rdata_o;
  // Shared RAM port
  logic                 mem_en_o;
  logic                 mem_we_o;
  logic [MEM_WIDTH-3:0] mem_addr_o;
  logic [31:0]          mem_wdata_o;
  logic [31:0]          mem_rdata_i;

  modport slave (
    input  i_req_i, i_addr_i, d_req_i, d_we_i, d_addr_i, d_wdata_i, mem_rdata_i,
    output i_gnt_o, i_rvalid_o, i_rdata_o, d_gnt_o, d_rvalid_o, d_rdata_o,
           mem_en_o, mem_we_o, mem_addr_o, mem_wdata_o
  );

  modport master (
    output i_req_i, i_addr_i, d_req_i, d_we_i, d_addr_i, d_wdata_i, mem_rdata_i,
    input  i_gnt_o, i_rvalid_o, i_rdata_o, d_gnt_o, d_rvalid_o, d_rdata_o,
           mem_en_o, mem_we_o, mem_addr_o, mem_wdata_o
  );
endinterface

// File: rtl/mem_arbiter.sv
// Two-port arbiter sharing one single-cycle-latency RAM between an
// instruction fetch port and a data port. Data normally wins; a starvation
// counter forces a fetch grant after STARVE_LIMIT consecutive data grants
// taken while a fetch was waiting. Read responses are routed one cycle later
// by a response-owner register, giving full back-to-back throughput.
module mem_arbiter #(
  parameter int MEM_WIDTH    = 10,
  parameter int STARVE_LIMIT = 2
) (
  input  logic          clk,
  input  logic          reset,
  mem_arbiter_if.slave  bus
);

  localparam int SW = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
  localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

  localparam logic [1:0] OWN_NONE = 2'd0;
  localparam logic [1:0] OWN_INST = 2'd1;
  localparam logic [1:0] OWN_DATA = 2'd2;

  logic [1:0]    resp_own;
  logic [SW-1:0] starve_cnt;
  logic          fetch_gnt;
  logic          data_gnt;

  // Address bits outside the RAM word range are deliberately ignored.
  logic addr_unused;
  assign addr_unused = &{bus.i_addr_i[31:MEM_WIDTH], bus.i_addr_i[1:0],
                         bus.d_addr_i[31:MEM_WIDTH], bus.d_addr_i[1:0]};

  // Grant selection: data first unless the waiting fetch has hit the starve limit.
  always_comb begin
    fetch_gnt = 1'b0;
    data_gnt  = 1'b0;
    if (!reset) begin
      if (bus.i_req_i && (!bus.d_req_i || (starve_cnt == STARVE_MAX))) begin
        fetch_gnt = 1'b1;
      end else if (bus.d_req_i) begin
        data_gnt = 1'b1;
      end
    end
  end

  // RAM port mux: steer the granted requester's address and write controls.
  always_comb begin
    bus.mem_en_o    = fetch_gnt | data_gnt;
    bus.mem_we_o    = data_gnt & bus.d_we_i;
    bus.mem_wdata_o = bus.d_wdata_i;
    if (data_gnt) begin
      bus.mem_addr_o = bus.d_addr_i[MEM_WIDTH-1:2];
    end else begin
      bus.mem_addr_o = bus.i_addr_i[MEM_WIDTH-1:2];
    end
  end

  // Starvation counter: counts data grants that overtake a waiting fetch.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      starve_cnt <= '0;
    end else if (fetch_gnt || !bus.i_req_i) begin
      starve_cnt <= '0;
    end else if (data_gnt && (starve_cnt != STARVE_MAX)) begin
      starve_cnt <= starve_cnt + 1'b1;
    end
  end

  // Response owner: remembers who gets the RAM read data on the next cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      resp_own <= OWN_NONE;
    end else if (fetch_gnt) begin
      resp_own <= OWN_INST;
    end else if (data_gnt && !bus.d_we_i) begin
      resp_own <= OWN_DATA;
    end else begin
      resp_own <= OWN_NONE;
    end
  end

  assign bus.i_gnt_o    = fetch_gnt;
  assign bus.d_gnt_o    = data_gnt;
  assign bus.i_rvalid_o = (resp_own == OWN_INST);
  assign bus.d_rvalid_o = (resp_own == OWN_DATA);
  assign bus.i_rdata_o  = bus.mem_rdata_i;
  assign bus.d_rdata_o  = bus.mem_rdata_i;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: the stimulus process checks grants and
// RAM-port values directly and queues the expected read responses; a monitor
// on the falling edge pops and checks every rvalid, including its cycle.
module tb_mem_arbiter;

  logic clk;
  logic reset;
  int   cyc;
  int   checks;
  int   errors;

  typedef struct {
    logic [31:0] data;
    int          cyc;
  } exp_t;

  exp_t iq[$];
  exp_t dq[$];

  logic [31:0] ram [0:255];

  mem_arbiter_if #(.MEM_WIDTH(10)) bus ();

  mem_arbiter #(.MEM_WIDTH(10), .STARVE_LIMIT(2)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // RAM model: synchronous write, registered read
  initial begin
    for (int k = 0; k < 256; k++) ram[k] = 32'hA500_0000 + k;
  end
  always @(posedge clk) begin
    if (bus.mem_en_o && bus.mem_we_o) ram[bus.mem_addr_o] <= bus.mem_wdata_o;
    if (bus.mem_en_o && !bus.mem_we_o) bus.mem_rdata_i <= ram[bus.mem_addr_o];
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Response monitor
  always @(negedge clk) begin
    exp_t e;
    if (bus.i_rvalid_o && bus.d_rvalid_o) chk("both_rvalid", 32'd1, 32'd0);
    if (bus.i_rvalid_o) begin
      if (iq.size() == 0) begin
        chk("unexpected_i_rvalid", 32'd1, 32'd0);
      end else begin
        e = iq.pop_front();
        chk("i_rvalid_cycle", cyc, e.cyc);
        chk("i_rdata", bus.i_rdata_o, e.data);
        $display("resp I data=%h cycle=%0d", bus.i_rdata_o, cyc);
      end
    end
    if (bus.d_rvalid_o) begin
      if (dq.size() == 0) begin
        chk("unexpected_d_rvalid", 32'd1, 32'd0);
      end else begin
        e = dq.pop_front();
        chk("d_rvalid_cycle", cyc, e.cyc);
        chk("d_rdata", bus.d_rdata_o, e.data);
        $display("resp D data=%h cycle=%0d", bus.d_rdata_o, cyc);
      end
    end
  end

  task automatic drive(input logic ireq, input logic [31:0] iaddr, input logic dreq,
                       input logic dwe, input logic [31:0] daddr, input logic [31:0] dwdata);
    bus.i_req_i   = ireq;
    bus.i_addr_i  = iaddr;
    bus.d_req_i   = dreq;
    bus.d_we_i    = dwe;
    bus.d_addr_i  = daddr;
    bus.d_wdata_i = dwdata;
  endtask

  // One cycle: drive, check grant/RAM port at the falling edge, queue expected read.
  task automatic step(input string name,
                      input logic ireq, input logic [31:0] iaddr, input logic dreq,
                      input logic dwe, input logic [31:0] daddr, input logic [31:0] dwdata,
                      input logic exp_i, input logic exp_d, input logic [7:0] exp_addr,
                      input logic [31:0] exp_rdata);
    exp_t e;
    drive(ireq, iaddr, dreq, dwe, daddr, dwdata);
    @(negedge clk);
    chk({name, ".i_gnt"}, 32'(bus.i_gnt_o), 32'(exp_i));
    chk({name, ".d_gnt"}, 32'(bus.d_gnt_o), 32'(exp_d));
    chk({name, ".mem_en"}, 32'(bus.mem_en_o), 32'(exp_i | exp_d));
    chk({name, ".mem_we"}, 32'(bus.mem_we_o), 32'(exp_d & dwe));
    if (exp_i || exp_d) chk({name, ".mem_addr"}, 32'(bus.mem_addr_o), 32'(exp_addr));
    if (exp_d && dwe) chk({name, ".mem_wdata"}, bus.mem_wdata_o, dwdata);
    $display("txn %s cycle=%0d i_gnt=%b d_gnt=%b en=%b we=%b addr=%0d",
             name, cyc, bus.i_gnt_o, bus.d_gnt_o, bus.mem_en_o, bus.mem_we_o, bus.mem_addr_o);
    e.data = exp_rdata;
    e.cyc  = cyc + 1;
    if (exp_i) iq.push_back(e);
    else if (exp_d && !dwe) dq.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_outputs(input string name);
    chk({name, ".i_gnt"}, 32'(bus.i_gnt_o), 32'd0);
    chk({name, ".d_gnt"}, 32'(bus.d_gnt_o), 32'd0);
    chk({name, ".mem_en"}, 32'(bus.mem_en_o), 32'd0);
    chk({name, ".mem_we"}, 32'(bus.mem_we_o), 32'd0);
    chk({name, ".i_rvalid"}, 32'(bus.i_rvalid_o), 32'd0);
    chk({name, ".d_rvalid"}, 32'(bus.d_rvalid_o), 32'd0);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset  = 1'b1;
    drive(1'b1, 32'h10, 1'b1, 1'b1, 32'h20, 32'h1234_5678);
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_reset_outputs("reset");
    $display("txn reset cycle=%0d", cyc);
    @(posedge clk);
    #1;
    reset = 1'b0;

    // name               ireq iaddr         dreq we  daddr         wdata         I  D  addr exp_rdata
    step("fetch_0x10",    1, 32'h10,        0, 0, 32'h0,        32'h0,        1, 0, 4,   32'hA500_0004);
    step("both_d_wins",   1, 32'h40,        1, 0, 32'h20,       32'h0,        0, 1, 8,   32'hA500_0008);
    step("idle",          0, 32'h0,         0, 0, 32'h0,        32'h0,        0, 0, 0,   32'h0);
    // Starvation: both held for four cycles -> D, D, I, D
    step("starve_1",      1, 32'h40,        1, 0, 32'h44,       32'h0,        0, 1, 17,  32'hA500_0011);
    step("starve_2",      1, 32'h40,        1, 0, 32'h48,       32'h0,        0, 1, 18,  32'hA500_0012);
    step("starve_3",      1, 32'h40,        1, 0, 32'h4C,       32'h0,        1, 0, 16,  32'hA500_0010);
    step("starve_4",      1, 32'h50,        1, 0, 32'h4C,       32'h0,        0, 1, 19,  32'hA500_0013);
    // Back-to-back alternating owners
    step("alt_fetch",     1, 32'h50,        0, 0, 32'h0,        32'h0,        1, 0, 20,  32'hA500_0014);
    step("alt_data",      0, 32'h0,         1, 0, 32'h24,       32'h0,        0, 1, 9,   32'hA500_0009);
    step("alt_fetch2",    1, 32'h28,        0, 0, 32'h0,        32'h0,        1, 0, 10,  32'hA500_000A);
    // Write then read back through the fetch port
    step("write_3fc",     0, 32'h0,         1, 1, 32'h3FC,      32'hDEAD_BEEF, 0, 1, 255, 32'h0);
    step("after_write",   0, 32'h0,         0, 0, 32'h0,        32'h0,        0, 0, 0,   32'h0);
    step("fetch_3fc",     1, 32'h3FC,       0, 0, 32'h0,        32'h0,        1, 0, 255, 32'hDEAD_BEEF);
    // Address wrap and ignored upper bits
    step("fetch_wrap",    1, 32'h0000_0404, 0, 0, 32'h0,        32'h0,        1, 0, 1,   32'hA500_0001);
    step("data_hibits",   0, 32'h0,         1, 0, 32'hFFFF_F00F, 32'h0,       0, 1, 3,   32'hA500_0003);
    step("idle2",         0, 32'h0,         0, 0, 32'h0,        32'h0,        0, 0, 0,   32'h0);

    // Reset while a fetch read is outstanding: the response must be dropped
    drive(1'b1, 32'h10, 1'b0, 1'b0, 32'h0, 32'h0);
    @(negedge clk);
    chk("midread.i_gnt", 32'(bus.i_gnt_o), 32'd1);
    $display("txn midread_grant cycle=%0d i_gnt=%b", cyc, bus.i_gnt_o);
    reset = 1'b1;
    #1;
    chk_reset_outputs("midread_in_reset");
    @(posedge clk);
    #1;
    chk_reset_outputs("midread_after_edge");
    drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    reset = 1'b0;
    @(negedge clk);
    chk("midread.i_rvalid", 32'(bus.i_rvalid_o), 32'd0);
    $display("txn midread_release cycle=%0d i_rvalid=%b", cyc, bus.i_rvalid_o);
    @(posedge clk);
    #1;
    // Recovery: first grant right after reset release, starvation counter cleared
    step("post_reset",    1, 32'h08,        1, 0, 32'h0C,       32'h0,        0, 1, 3,   32'hA500_0003);
    step("post_reset_i",  1, 32'h08,        0, 0, 32'h0,        32'h0,        1, 0, 2,   32'hA500_0002);
    step("drain",         0, 32'h0,         0, 0, 32'h0,        32'h0,        0, 0, 0,   32'h0);
    step("drain2",        0, 32'h0,         0, 0, 32'h0,        32'h0,        0, 0, 0,   32'h0);

    chk("iq_empty", 32'(iq.size()), 32'd0);
    chk("dq_empty", 32'(dq.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
